// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_BURST_LEN = 4;
    localparam int DEF_CNT_WIDTH = 8;

    // Sized for the largest supported requester count (8).
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate so last+1 sits at bit 0, take the
// lowest set bit, rotate back.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] last,
    output logic [NUM_REQ-1:0]   winner,
    output logic [IDX_WIDTH-1:0] idx
);

    logic [IDX_WIDTH-1:0]   start;
    logic [2*NUM_REQ-1:0]   fwd;
    logic [2*NUM_REQ-1:0]   back;
    logic [NUM_REQ-1:0]     rotated;
    logic [NUM_REQ-1:0]     rot_oh;

    assign start   = (last == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : last + IDX_WIDTH'(1);
    assign fwd     = {req, req} >> start;
    assign rotated = fwd[NUM_REQ-1:0];
    assign rot_oh  = rotated & (~rotated + {{(NUM_REQ-1){1'b0}}, 1'b1});
    assign back    = {rot_oh, rot_oh} << start;
    assign winner  = back[2*NUM_REQ-1:NUM_REQ];
    assign idx     = IDX_WIDTH'(onehot_to_idx(8'(winner)));

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter in front of the async FIFO write port.
// Define WR_ARB_PRIO_EN to make requester 0 win every arbitration it enters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int IDX_WIDTH  = 2,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                          wclk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic [NUM_REQ-1:0]            grant,
    output logic [IDX_WIDTH-1:0]          grant_idx,
    output logic                          busy
);

    state_t               state;
    logic [IDX_WIDTH-1:0] last;
    logic [CNT_WIDTH-1:0] beats;
    logic [NUM_REQ-1:0]   pick_oh;
    logic [IDX_WIDTH-1:0] pick_idx;
    logic [NUM_REQ-1:0]   win_oh;
    logic [IDX_WIDTH-1:0] win_idx;
    logic                 owner_valid;
    logic                 transfer;
    logic                 last_beat;

    rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .req    (req_valid),
        .last   (last),
        .winner (pick_oh),
        .idx    (pick_idx)
    );

`ifdef WR_ARB_PRIO_EN
    assign win_oh  = req_valid[0] ? NUM_REQ'(1) : pick_oh;
    assign win_idx = req_valid[0] ? '0 : pick_idx;
`else
    assign win_oh  = pick_oh;
    assign win_idx = pick_idx;
`endif

    // grant is zero outside BURST, so these gate off on their own after reset.
    assign owner_valid = |(req_valid & grant);
    assign transfer    = (state == BURST) && owner_valid && !full;
    assign last_beat   = (beats == CNT_WIDTH'(BURST_LEN - 1));
    assign w_en        = transfer;
    assign req_ready   = grant & {NUM_REQ{transfer}};
    assign data_in     = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            beats     <= '0;
            last      <= IDX_WIDTH'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        state     <= BURST;
                        grant     <= win_oh;
                        grant_idx <= win_idx;
                        busy      <= 1'b1;
                        beats     <= '0;
                    end
                end
                BURST: begin
                    // Early release and count release collapse into one.
                    if (!owner_valid || (transfer && last_beat)) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        beats <= '0;
                        last  <= grant_idx;
                    end else if (transfer) begin
                        beats <= beats + CNT_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
